// File: rtl/tmr_err_mon_pkg.sv
// tmr_err_mon_pkg
//   Shared types and constants for the TMR error monitor.
//   - rd_state_e : readout FSM states (IDLE, SEND)
//   - DATA_BASE  : counter index of err_data_i[0]
//   - state_base : counter index of err_state_i[0] for a given lane count
`timescale 1ns/1ps
package tmr_err_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_e;

    localparam int unsigned DATA_BASE = 0;

    function automatic int unsigned state_base(input int unsigned lanes);
        return lanes;
    endfunction

endpackage

// File: rtl/tmr_err_ctr.sv
// tmr_err_ctr
//   One rising-edge detector feeding a saturating event counter.
//   Ports:
//     clk_i    in   clock
//     rst_i    in   asynchronous active-high reset
//     flag_i   in   level error flag
//     clr_i    in   synchronous clear of the count (prev flag kept)
//     reload_i in   snapshot reload: count becomes 0, or 1 if an edge now
//     cnt_o    out  current count [CW-1:0]
//     edge_o   out  rising edge of flag_i this cycle
`timescale 1ns/1ps
module tmr_err_ctr #(
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flag_i,
    input  logic          clr_i,
    input  logic          reload_i,
    output logic [CW-1:0] cnt_o,
    output logic          edge_o
);

    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise;

    assign rise = flag_i & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (reload_i) begin
            cnt_d = rise ? CW'(1) : '0;
        end else if (rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // prev is deliberately not cleared by clr_i so a held flag is not recounted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= flag_i;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign edge_o = rise;

endmodule

// File: rtl/tmr_err_monitor.sv
// tmr_err_monitor
//   Counts rising edges of per-lane TMR error flags in saturating counters,
//   keeps a sticky any-error flag and streams a snapshot of all counters
//   over a valid/ready port on request.
//   Counter i < L tracks err_data_i[i]; counter L+i tracks err_state_i[i].
//   Ports:
//     clk_i, rst_i           clock, asynchronous active-high reset
//     err_data_i[L]          data-voter mismatch flags
//     err_state_i[L]         state-voter mismatch flags
//     clr_i                  clear counters and err_any_o
//     rd_req_i               readout request (IDLE only)
//     rd_ready_i             consumer ready
//     rd_valid_o, rd_data_o  readout word
//     rd_idx_o, rd_last_o    word index, final-word marker
//     busy_o                 readout in progress
//     err_any_o              sticky error flag
//   Build option: TMR_ERR_MON_CLR_ON_READ_EN reloads the counters on snapshot.
`timescale 1ns/1ps
module tmr_err_monitor
    import tmr_err_mon_pkg::*;
#(
    parameter int unsigned L  = 2,
    parameter int unsigned CW = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [L-1:0]             err_data_i,
    input  logic [L-1:0]             err_state_i,
    input  logic                     clr_i,
    input  logic                     rd_req_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [CW-1:0]            rd_data_o,
    output logic [$clog2(2*L)-1:0]   rd_idx_o,
    output logic                     rd_last_o,
    output logic                     busy_o,
    output logic                     err_any_o
);

    localparam int unsigned N          = 2 * L;
    localparam int unsigned IW         = $clog2(N);
    localparam int unsigned STATE_BASE = state_base(L);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [N-1:0]  flags;
    logic [N-1:0]  rises;
    logic [CW-1:0] cnt    [N];
    logic [CW-1:0] snap_q [N];

    rd_state_e     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          snap_take;
    logic          reload;
    logic          err_any_q;

    assign flags[DATA_BASE  +: L] = err_data_i;
    assign flags[STATE_BASE +: L] = err_state_i;

`ifdef TMR_ERR_MON_CLR_ON_READ_EN
    assign reload = snap_take;
`else
    assign reload = 1'b0;
`endif

    for (genvar g = 0; g < N; g++) begin : g_ctr
        tmr_err_ctr #(
            .CW(CW)
        ) u_ctr (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .flag_i   (flags[g]),
            .clr_i    (clr_i),
            .reload_i (reload),
            .cnt_o    (cnt[g]),
            .edge_o   (rises[g])
        );
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req_i) begin
                    snap_take = 1'b1;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (rd_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        rd_valid_o = (state_q == SEND);
        busy_o     = (state_q != IDLE);
        rd_idx_o   = idx_q;
        rd_last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
        rd_data_o  = (state_q == SEND) ? snap_q[idx_q] : '0;
    end

    // Snapshot holds the counter values from before this edge's update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            err_any_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            idx_q <= idx_d;
            if (snap_take) begin
                for (int unsigned i = 0; i < N; i++) begin
                    snap_q[i] <= cnt[i];
                end
            end
            if (clr_i) begin
                err_any_q <= 1'b0;
            end else if (|rises) begin
                err_any_q <= 1'b1;
            end
        end
    end

    assign err_any_o = err_any_q;

endmodule

// File: tb/tb_tmr_err_monitor.sv
`timescale 1ns/1ps
module tb_tmr_err_monitor;

    localparam int L  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [L-1:0]  err_data_i;
    logic [L-1:0]  err_state_i;
    logic          clr_i;
    logic          rd_req_i;
    logic          rd_ready_i;
    logic          rd_valid_o;
    logic [CW-1:0] rd_data_o;
    logic [1:0]    rd_idx_o;
    logic          rd_last_o;
    logic          busy_o;
    logic          err_any_o;

    int checks = 0;
    int errors = 0;

    tmr_err_monitor #(
        .L  (L),
        .CW (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .err_data_i  (err_data_i),
        .err_state_i (err_state_i),
        .clr_i       (clr_i),
        .rd_req_i    (rd_req_i),
        .rd_ready_i  (rd_ready_i),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_idx_o    (rd_idx_o),
        .rd_last_o   (rd_last_o),
        .busy_o      (busy_o),
        .err_any_o   (err_any_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flag(input int which, input logic v);
        if (which < L) err_data_i[which] = v;
        else           err_state_i[which - L] = v;
    endtask

    task automatic edges(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            set_flag(which, 1'b1);
            tick();
            set_flag(which, 1'b0);
            tick();
        end
    endtask

    task automatic clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic read_all(input string tag,
                            input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                            input logic [CW-1:0] w2, input logic [CW-1:0] w3,
                            input int stall_idx, input int stall_n);
        logic [CW-1:0] ew [4];
        ew = '{w0, w1, w2, w3};
        rd_ready_i = 1'b0;
        rd_req_i   = 1'b1;
        tick();
        rd_req_i   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_valid%0d", tag, k), rd_valid_o, 1);
            check($sformatf("%s_busy%0d", tag, k), busy_o, 1);
            check($sformatf("%s_idx%0d", tag, k), rd_idx_o, k);
            check($sformatf("%s_data%0d", tag, k), rd_data_o, ew[k]);
            check($sformatf("%s_last%0d", tag, k), rd_last_o, (k == 3) ? 1 : 0);
            if (k == stall_idx) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check($sformatf("%s_hold_valid%0d", tag, s), rd_valid_o, 1);
                    check($sformatf("%s_hold_idx%0d", tag, s), rd_idx_o, k);
                    check($sformatf("%s_hold_data%0d", tag, s), rd_data_o, ew[k]);
                end
            end
            rd_ready_i = 1'b1;
            tick();
            rd_ready_i = 1'b0;
        end
        check($sformatf("%s_done_busy", tag), busy_o, 0);
        check($sformatf("%s_done_valid", tag), rd_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] reread;
        rst_i       = 1'b1;
        err_data_i  = '0;
        err_state_i = '0;
        clr_i       = 1'b0;
        rd_req_i    = 1'b0;
        rd_ready_i  = 1'b0;
        tick();
        tick();
        check("rst_valid", rd_valid_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_idx", rd_idx_o, 0);
        check("rst_last", rd_last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err_any", err_any_o, 0);
        rst_i = 1'b0;
        tick();

        // single 3-cycle pulse on err_data_i[1]
        err_data_i[1] = 1'b1;
        tick(); tick(); tick();
        err_data_i[1] = 1'b0;
        tick();
        check("pulse_err_any", err_any_o, 1);
        read_all("pulse", 0, 1, 0, 0, -1, 0);

        clear();
        check("clr_err_any", err_any_o, 0);

        // five edges on err_state_i[0], stall two cycles on word 2
        edges(2, 5);
        read_all("multi", 0, 0, 5, 0, 2, 2);

        // saturation at 15 with CW=4
        clear();
        edges(0, 20);
        check("sat_err_any", err_any_o, 1);
        read_all("sat", 15, 0, 0, 0, -1, 0);

        // clear colliding with an edge
        clear();
        edges(0, 3);
        err_data_i[0] = 1'b1;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("coll_err_any", err_any_o, 0);
        tick();
        check("coll_held_err_any", err_any_o, 0);
        read_all("coll", 0, 0, 0, 0, -1, 0);
        err_data_i[0] = 1'b0;
        tick();
        err_data_i[0] = 1'b1;
        tick();
        check("coll_next_err_any", err_any_o, 1);
        err_data_i[0] = 1'b0;
        tick();
        read_all("coll_next", 1, 0, 0, 0, -1, 0);

        // clear-on-read behaviour
        clear();
        edges(3, 2);
        read_all("cor1", 0, 0, 0, 2, -1, 0);
`ifdef TMR_ERR_MON_CLR_ON_READ_EN
        reread = 0;
`else
        reread = 2;
`endif
        read_all("cor2", 0, 0, 0, reread, -1, 0);

        // reset during word 1
        clear();
        edges(1, 1);
        rd_req_i = 1'b1;
        tick();
        rd_req_i   = 1'b0;
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        check("mid_idx", rd_idx_o, 1);
        check("mid_data", rd_data_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", rd_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_err_any", err_any_o, 0);
        tick();
        rst_i = 1'b0;
        tick();
        read_all("post_rst", 0, 0, 0, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
